// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared constants and the FSM state encoding for the score BCD converter.
//   BCD_BLANK  : nibble code that the 7-segment driver renders as a blank digit
//   NUM_DIGITS : number of decimal digits produced (thousands..ones)
//   state_t    : converter FSM states (IDLE / SHIFT / FINISH)
// -----------------------------------------------------------------------------
package bcd_pkg;

  localparam logic [3:0] BCD_BLANK  = 4'hF;
  localparam int         NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

endpackage : bcd_pkg

// File: rtl/bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Double-dabble nibble correction: a digit of 5 or more gets 3 added so that
// the following left shift carries correctly into the next decimal digit.
// Ports:
//   i_nib : BCD nibble before correction
//   o_nib : corrected nibble (i_nib >= 5 ? i_nib + 3 : i_nib)
// -----------------------------------------------------------------------------
module bcd_add3 (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  // Conditional add-3 on one nibble.
  always_comb begin
    o_nib = i_nib;
    if (i_nib >= 4'd5) begin
      o_nib = i_nib + 4'd3;
    end else begin
      o_nib = i_nib;
    end
  end

endmodule : bcd_add3

// File: rtl/score_bcd_converter.sv
// -----------------------------------------------------------------------------
// score_bcd_converter
// Sequential binary-to-BCD converter (double dabble, one iteration per clock)
// feeding the 4-digit 7-segment display driver. Digit outputs only change on
// conversion completion, so the display never shows intermediate values.
// Ports:
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   start     : conversion request, only honoured in IDLE
//   bin       : binary score, captured on the accepting edge
//   busy      : conversion in progress
//   done      : one-cycle completion pulse
//   overflow  : last input exceeded MAX_VAL (digits saturated to MAX_VAL)
//   val1..4   : thousands..ones digit; leading zeros of val1..val3 blanked
//               to BCD_BLANK when BLANK_LZ=1, val4 never blanked
// -----------------------------------------------------------------------------
module score_bcd_converter
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 14,
  parameter int MAX_VAL   = 9999,
  parameter bit BLANK_LZ  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] bin,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [3:0]           val1,
  output logic [3:0]           val2,
  output logic [3:0]           val3,
  output logic [3:0]           val4
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int SR_W  = BCD_W + BIN_WIDTH;
  localparam int CNT_W = $clog2(BIN_WIDTH);

  localparam logic [BIN_WIDTH-1:0] MAX_BIN  = BIN_WIDTH'(MAX_VAL);
  localparam logic [CNT_W-1:0]     LAST_IT  = CNT_W'(BIN_WIDTH - 1);
  // Reset value for a leading digit: the converted value 0 shows as blank.
  localparam logic [3:0]           RST_LEAD = BLANK_LZ ? BCD_BLANK : 4'h0;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [SR_W-1:0]      r_sr;       // {bcd[15:0], bin[BIN_WIDTH-1:0]}
  logic                 r_ovf_pend;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_overflow;
  logic [3:0]           r_val1;
  logic [3:0]           r_val2;
  logic [3:0]           r_val3;
  logic [3:0]           r_val4;

  logic [BIN_WIDTH-1:0] w_bin_sat;
  logic                 w_bin_ovf;
  logic [BCD_W-1:0]     w_bcd_corr;
  logic [SR_W-1:0]      w_sr_shift;
  logic [3:0]           w_d3;
  logic [3:0]           w_d2;
  logic [3:0]           w_d1;
  logic [3:0]           w_d0;
  logic                 w_lz1;
  logic                 w_lz2;
  logic                 w_lz3;

  // Add-3 correction on every BCD nibble of the shift register.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_nib (r_sr[BIN_WIDTH + 4*g +: 4]),
      .o_nib (w_bcd_corr[4*g +: 4])
    );
  end

  // Correct first, then shift; the top BCD bit shifted out is always 0 for
  // inputs saturated to 9999.
  assign w_sr_shift = {w_bcd_corr, r_sr[BIN_WIDTH-1:0]} << 1;

  assign w_bin_ovf  = (bin > MAX_BIN);
  assign w_bin_sat  = w_bin_ovf ? MAX_BIN : bin;

  assign w_d3 = r_sr[SR_W-1   -: 4];
  assign w_d2 = r_sr[SR_W-5   -: 4];
  assign w_d1 = r_sr[SR_W-9   -: 4];
  assign w_d0 = r_sr[SR_W-13  -: 4];

  // A digit is a leading zero only if every digit to its left is one too.
  assign w_lz1 = BLANK_LZ && (w_d3 == 4'h0);
  assign w_lz2 = w_lz1 && (w_d2 == 4'h0);
  assign w_lz3 = w_lz2 && (w_d1 == 4'h0);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == LAST_IT) begin
          w_state_nxt = ST_FINISH;
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: capture, iterate, and publish the result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_sr       <= '0;
      r_ovf_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_val1     <= RST_LEAD;
      r_val2     <= RST_LEAD;
      r_val3     <= RST_LEAD;
      r_val4     <= 4'h0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sr       <= {{BCD_W{1'b0}}, w_bin_sat};
            r_ovf_pend <= w_bin_ovf;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
          end
        end
        ST_SHIFT: begin
          r_sr  <= w_sr_shift;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        ST_FINISH: begin
          r_val1     <= w_lz1 ? BCD_BLANK : w_d3;
          r_val2     <= w_lz2 ? BCD_BLANK : w_d2;
          r_val3     <= w_lz3 ? BCD_BLANK : w_d1;
          r_val4     <= w_d0;
          r_overflow <= r_ovf_pend;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_overflow;
  assign val1     = r_val1;
  assign val2     = r_val2;
  assign val3     = r_val3;
  assign val4     = r_val4;

endmodule : score_bcd_converter

// File: tb/tb_score_bcd_converter.sv
// -----------------------------------------------------------------------------
// tb_score_bcd_converter
// Directed bench for score_bcd_converter: one instance with leading-zero
// blanking, one without, sharing all inputs. Expected digits hand-computed.
// -----------------------------------------------------------------------------
module tb_score_bcd_converter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [13:0] bin;
  logic        busy, done, overflow;
  logic [3:0]  v1, v2, v3, v4;
  logic        nb_busy, nb_done, nb_overflow;
  logic [3:0]  nb_v1, nb_v2, nb_v3, nb_v4;

  int n_tests;
  int n_fail;

  score_bcd_converter #(.BIN_WIDTH(14), .MAX_VAL(9999), .BLANK_LZ(1'b1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .overflow(overflow),
    .val1(v1), .val2(v2), .val3(v3), .val4(v4)
  );

  score_bcd_converter #(.BIN_WIDTH(14), .MAX_VAL(9999), .BLANK_LZ(1'b0)) u_dut_nb (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(nb_busy), .done(nb_done), .overflow(nb_overflow),
    .val1(nb_v1), .val2(nb_v2), .val3(nb_v3), .val4(nb_v4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One conversion: start pulse, bounded wait for done, then check result.
  task automatic do_conv(input string tag, input logic [13:0] b,
                         input logic [15:0] exp_v, input logic exp_ovf,
                         input logic [15:0] exp_nb);
    int lat;
    int busy_n;
    lat    = 0;
    busy_n = 0;
    @(negedge clk);
    start = 1'b1;
    bin   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    bin   = 14'h1555;   // must not affect the running conversion
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end else if (busy) begin
        busy_n++;
      end
    end
    check({tag, "_latency"}, 16'(lat), 16'd16);
    check({tag, "_busy_cycles"}, 16'(busy_n), 16'd15);
    check({tag, "_busy_at_done"}, {15'd0, busy}, 16'd0);
    check({tag, "_vals"}, {v1, v2, v3, v4}, exp_v);
    check({tag, "_ovf"}, {15'd0, overflow}, {15'd0, exp_ovf});
    check({tag, "_vals_noblank"}, {nb_v1, nb_v2, nb_v3, nb_v4}, exp_nb);
    check({tag, "_ovf_noblank"}, {15'd0, nb_overflow}, {15'd0, exp_ovf});
    @(negedge clk);
    check({tag, "_done_pulse"}, {15'd0, done}, 16'd0);
    check({tag, "_hold"}, {v1, v2, v3, v4}, exp_v);
  endtask

  initial begin
    int t1, t2, done_seen;
    n_tests = 0;
    n_fail  = 0;
    start   = 1'b0;
    bin     = 14'd0;
    rst     = 1'b0;

    // Asynchronous reset, asserted between clock edges.
    #1 rst = 1'b1;
    #1;
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    check("rst_ovf", {15'd0, overflow}, 16'd0);
    check("rst_vals", {v1, v2, v3, v4}, 16'hFFF0);
    check("rst_vals_noblank", {nb_v1, nb_v2, nb_v3, nb_v4}, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_conv("b2048",  14'd2048,  16'h2048, 1'b0, 16'h2048);
    do_conv("b7",     14'd7,     16'hFFF7, 1'b0, 16'h0007);
    do_conv("b0",     14'd0,     16'hFFF0, 1'b0, 16'h0000);
    do_conv("b100",   14'd100,   16'hF100, 1'b0, 16'h0100);
    do_conv("b9999",  14'd9999,  16'h9999, 1'b0, 16'h9999);
    do_conv("b12000", 14'd12000, 16'h9999, 1'b1, 16'h9999);
    do_conv("b16",    14'd16,    16'hFF16, 1'b0, 16'h0016);
    do_conv("b10000", 14'd10000, 16'h9999, 1'b1, 16'h9999);
    do_conv("b16383", 14'd16383, 16'h9999, 1'b1, 16'h9999);

    // Start held high; bin changes mid-conversion; second start taken in done cycle.
    t1 = 0;
    t2 = 0;
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd512;
    @(posedge clk);
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 3) begin
        bin = 14'd64;
      end
      if (done) begin
        if (t1 == 0) begin
          t1 = i;
          check("hs_first_vals", {v1, v2, v3, v4}, 16'hF512);
          check("hs_first_noblank", {nb_v1, nb_v2, nb_v3, nb_v4}, 16'h0512);
        end else begin
          t2 = i;
          start = 1'b0;
          check("hs_second_vals", {v1, v2, v3, v4}, 16'hFF64);
          check("hs_second_noblank", {nb_v1, nb_v2, nb_v3, nb_v4}, 16'h0064);
          break;
        end
      end
    end
    start = 1'b0;
    check("hs_first_latency", 16'(t1), 16'd16);
    check("hs_spacing", 16'(t2 - t1), 16'd16);
    repeat (3) @(negedge clk);
    check("hs_idle_after", {15'd0, busy}, 16'd0);

    // Abort: reset asserted mid-SHIFT after an overflowed result.
    do_conv("b12000b", 14'd12000, 16'h9999, 1'b1, 16'h9999);
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd1024;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(negedge clk);
    check("abort_busy_before", {15'd0, busy}, 16'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", {15'd0, busy}, 16'd0);
    check("abort_done", {15'd0, done}, 16'd0);
    check("abort_ovf", {15'd0, overflow}, 16'd0);
    check("abort_vals", {v1, v2, v3, v4}, 16'hFFF0);
    check("abort_vals_noblank", {nb_v1, nb_v2, nb_v3, nb_v4}, 16'h0000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        done_seen++;
      end
    end
    check("abort_no_done", 16'(done_seen), 16'd0);
    check("abort_vals_kept", {v1, v2, v3, v4}, 16'hFFF0);
    do_conv("b32", 14'd32, 16'hFF32, 1'b0, 16'h0032);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_score_bcd_converter

// File: doc/score_bcd_converter.md
Name: score_bcd_converter

Overview:
Sequential binary-to-BCD converter that sits between the game score register and the 4-digit 7-segment display driver. It converts the game score into four decimal digits using double-dabble (shift-and-add-3), one iteration per clock. It presents the digits on the display driver's val1..val4 inputs, with optional leading-zero blanking. Outputs change only at conversion completion, so the display never shows intermediate values.

Parameters:
BIN_WIDTH, 14, width of binary input (max 16383)
MAX_VAL, 9999, saturation limit (largest 4-digit decimal)
BLANK_LZ, 1, when 1 leading zero digits are driven as 4'hF (display blank code)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
start  input  1  request conversion of bin; sampled only in IDLE
bin  input  BIN_WIDTH  binary score; captured on the accepting edge only
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse; val1..val4 and overflow valid from this cycle on
overflow  output  1  bin exceeded MAX_VAL on last conversion (result saturated)
val1  output  4  thousands digit (leftmost display)
val2  output  4  hundreds digit
val3  output  4  tens digit
val4  output  4  ones digit (rightmost display), never blanked

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, overflow=0; iteration counter=0, shift register=0. Digits equal the converted value 0: BLANK_LZ=1 gives val1..val4 = F,F,F,0; BLANK_LZ=0 gives 0,0,0,0.
- FSM states: IDLE, SHIFT, FINISH.
- IDLE: if start=1 at edge k:
  - capture min(bin, MAX_VAL) into the binary part of the shift register; clear the BCD part.
  - latch ovf_pending = (bin > MAX_VAL).
  - counter=0, go to SHIFT, busy=1.
- SHIFT: per edge, add 3 to each BCD nibble >= 5, then shift the whole {bcd, bin} register left 1. Counter increments. After BIN_WIDTH iterations (edges k+1..k+14), go to FINISH.
- FINISH (edge k+15):
  - register val1..val4 from BCD nibbles. If BLANK_LZ=1, replace leading zeros in val1..val3 with 4'hF; stop at the first nonzero digit.
  - overflow <= ovf_pending; done=1 for exactly one cycle; busy=0; return to IDLE.
- Latency: start accepted at edge k, done high in the cycle after edge k+15 (15 clocks). Throughput: one conversion per 16 clocks.
- start while busy (SHIFT/FINISH): ignored, not queued. start high during the done cycle: accepted (state is IDLE).
- val1..val4 and overflow hold their value between done pulses. bin changes while busy have no effect.
- Embedded zeros (e.g. 100) are never blanked; only zeros left of the first nonzero digit are.
- Reset mid-conversion: immediate abort to reset values. No done pulse is issued. Previously displayed digits are replaced by the reset digits.
- Width rules: BCD register is 16 bits. Add-3 is applied before the shift; the final shift has no correction after it.

Decomposition:
- Shared package (bcd_pkg): BCD_BLANK = 4'hF, NUM_DIGITS = 4, state encoding (IDLE/SHIFT/FINISH).
- One sub-module: bcd_add3, a combinational 4-bit nibble correction (in >= 5 ? in+3 : in), instantiated 4 times.
- Blanking logic stays inline.

Test Plan:
- Reset: assert rst asynchronously (not on a clock edge) -> immediately busy=0, done=0, overflow=0, vals=F,F,F,0.
- bin=2048, start pulse at edge k -> busy 1 for 15 cycles; done single pulse after edge k+15; vals=2,0,4,8; overflow=0.
- Blanking: bin=7 -> F,F,F,7; bin=0 -> F,F,F,0; bin=100 -> F,1,0,0; bin=9999 -> 9,9,9,9. With BLANK_LZ=0, bin=7 -> 0,0,0,7.
- Saturation: bin=12000 -> vals=9,9,9,9, overflow=1. Next conversion with bin=16 -> F,F,1,6, overflow=0.
- Handshake: start held high continuously, bin=512 then changed to 64 at cycle 3 -> first result 5,1,2 (F,5,1,2); second conversion accepted in the done cycle yields F,F,6,4 exactly 16 clocks after the first done.
- Abort: bin=1024, assert rst at cycle 7 of SHIFT -> busy=0 immediately, vals=F,F,F,0, no done. After release, a new start with bin=32 gives F,F,3,2.
